uart_trx_param: RTL and testbench
=================================

Name: uart_trx_param

Overview:
Parametrised full-duplex UART transceiver; successor to the fixed 8-bit Rx/Tx core instantiated under the TinyTapeout top.
- Adds configurable bit period, data width and parity.
- Adds a receive FIFO with ready/valid drain, plus overrun, framing and parity flags.
- Sits directly behind tt_um top pins: txd/rxd map to uio pins, byte interfaces map to ui_in/uo_out.

Parameters:
- CLK_DIV, 16: clock cycles per bit period; legal range 4..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 4: RX FIFO entries; power of 2, at least 2.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- tx_data, input, DATA_BITS: byte to transmit.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: transmitter idle; accepts a byte.
- txd, output, 1: serial out; idles high.
- rxd, input, 1: serial in; asynchronous to clk.
- rx_data, output, DATA_BITS: FIFO head, show-ahead.
- rx_valid, output, 1: FIFO not empty.
- rx_ready, input, 1: pop FIFO head.
- rx_count, output, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- rx_overrun, output, 1: one-cycle pulse; good frame dropped because FIFO was full.
- rx_frame_err, output, 1: one-cycle pulse; stop bit sampled 0.
- rx_parity_err, output, 1: one-cycle pulse; parity mismatch.

Behaviour:
Reset values:
- txd=1, tx_ready=1, rx_valid=0, rx_count=0, all error pulses 0, rx_data=0.
- Both FSMs to IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately: txd returns to 1 asynchronously, the partial RX frame is discarded, and FIFO contents are lost.

TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
- tx_ready=1 only in IDLE. Handshake completes on tx_valid & tx_ready; tx_data is latched.
- txd drives 0 from the next cycle, for exactly CLK_DIV cycles.
- Data bits are sent LSB first, CLK_DIV cycles each.
- PARITY state is skipped when PARITY=0. The parity bit is the XOR of the data bits, inverted for odd parity.
- STOP drives 1 for CLK_DIV cycles, then returns to IDLE; tx_ready rises on that cycle.
- Back-to-back frames therefore have no idle gap beyond one stop bit.
- tx_valid while tx_ready=0 is ignored; tx_data is not required to be held.

RX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
- rxd passes through a 2-flop synchroniser initialised to 1.
- IDLE: a synchronised 1->0 transition enters START.
- START: wait CLK_DIV/2 cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE with no flag. Otherwise sample each later bit every CLK_DIV cycles, at mid-bit.
- STOP sample = 0: pulse rx_frame_err, discard the byte, return to IDLE. A new start edge is then only accepted after rxd is seen high.
- Parity mismatch: pulse rx_parity_err and discard the byte. If a stop-bit error occurs in the same frame, both flags pulse.
- A good frame pushes to the FIFO in the cycle after the stop sample.

FIFO:
- Push when not full. When full, the byte is dropped and rx_overrun pulses.
- Pop on rx_valid & rx_ready. rx_ready with rx_valid=0 is ignored.
- Simultaneous push and pop: count is unchanged, and both succeed even when full.
- Pointers wrap modulo FIFO_DEPTH. rx_data updates the cycle after a pop.

Optional Feature:
Macro UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the RX synchroniser input is txd instead of rxd, and txd still drives the pin.
- Not defined: the port is absent and RX always listens to rxd.

Test Plan:
1. CLK_DIV=16, PARITY=0: send 0xA5 -> txd low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_ready returns after 160 cycles.
2. Drive rxd with frame 0x3C -> rx_valid rises about 152 cycles after the start edge, with rx_data=0x3C. Pop with rx_ready -> rx_valid=0, rx_count=0.
3. FIFO_DEPTH=4, send 5 frames with no pops -> rx_count=4, rx_overrun pulses once on the 5th frame. Pops return the first 4 bytes in order.
4. PARITY=1: send 0x07 with parity bit 0 -> rx_parity_err pulses and the FIFO stays empty. The same frame with parity 1 is accepted.
5. rxd low pulse of 4 cycles -> no push, no flags. A frame with stop bit 0 -> rx_frame_err pulses and nothing is pushed.
6. Assert rst_n=0 mid-TX data bit -> txd=1 and tx_ready=1 immediately. After release, 0x55 transmits correctly.
   With UART_LOOPBACK_EN defined and loopback=1: send 0x81 -> received rx_data=0x81.

Source files
------------

// File: rtl/uart_trx_param.sv
// uart_trx_param -- parametrised full-duplex UART transceiver with RX FIFO.
//
// Parameters:
//   CLK_DIV    clock cycles per bit period (4..65535)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//   FIFO_DEPTH RX FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   loopback                (only with UART_LOOPBACK_EN) RX listens to txd
//   tx_data/tx_valid/tx_ready  transmit handshake; tx_ready high when idle
//   txd                     serial out, idles high
//   rxd                     serial in, asynchronous to clk
//   rx_data/rx_valid/rx_ready  show-ahead FIFO head with ready/valid pop
//   rx_count                FIFO occupancy
//   rx_overrun              pulse: good frame dropped, FIFO full
//   rx_frame_err            pulse: stop bit sampled low
//   rx_parity_err           pulse: parity mismatch
//
// Optional feature macro: UART_LOOPBACK_EN (adds the loopback input).

module uart_trx_param #(
   parameter int unsigned CLK_DIV    = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
`ifdef UART_LOOPBACK_EN
   input  logic                          loopback,
`endif
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   input  logic                          rxd,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          rx_overrun,
   output logic                          rx_frame_err,
   output logic                          rx_parity_err
);

   localparam int unsigned CW   = $clog2(CLK_DIV);
   localparam int unsigned BW   = $clog2(DATA_BITS);
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          HAS_PAR   = (PARITY != 0);
   localparam logic          ODD_PAR   = (PARITY == 2);

   // ------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

   tx_state_t              tx_state, tx_next;
   logic [CW-1:0]          tx_cnt;
   logic [BW-1:0]          tx_bit;
   logic [DATA_BITS-1:0]   tx_shift;
   logic                   tx_par;
   logic                   tx_tick;

   assign tx_tick = (tx_cnt == DIV_LAST);

   always_comb begin
      tx_next  = tx_state;
      txd      = 1'b1;
      tx_ready = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) tx_next = TX_START;
         end
         TX_START: begin
            txd = 1'b0;
            if (tx_tick) tx_next = TX_DATA;
         end
         TX_DATA: begin
            txd = tx_shift[0];
            if (tx_tick && tx_bit == BIT_LAST) tx_next = HAS_PAR ? TX_PAR : TX_STOP;
         end
         TX_PAR: begin
            txd = tx_par;
            if (tx_tick) tx_next = TX_STOP;
         end
         TX_STOP: begin
            if (tx_tick) tx_next = TX_IDLE;
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
      end else begin
         tx_state <= tx_next;
         if (tx_state == TX_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            if (tx_valid) begin
               tx_shift <= tx_data;
               tx_par   <= (^tx_data) ^ ODD_PAR;
            end
         end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            if (tx_state == TX_DATA && tx_tick) begin
               tx_shift <= tx_shift >> 1;
               tx_bit   <= tx_bit + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

   rx_state_t              rx_state, rx_next;
   logic                   rx_in, sync1, rx_s, rx_prev;
   logic [CW-1:0]          rx_cnt;
   logic [BW-1:0]          rx_bit;
   logic [DATA_BITS-1:0]   rx_shift;
   logic                   par_bad;
   logic                   half_tick, full_tick, stop_sample;
   logic                   push_req;

`ifdef UART_LOOPBACK_EN
   assign rx_in = loopback ? txd : rxd;
`else
   assign rx_in = rxd;
`endif

   assign half_tick   = (rx_cnt == HALF_LAST);
   assign full_tick   = (rx_cnt == DIV_LAST);
   assign stop_sample = (rx_state == RX_STOP) && full_tick;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         // rx_prev only goes high after the line is seen high, so a
         // held-low line after a framing error cannot re-trigger.
         RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
         RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && rx_bit == BIT_LAST) rx_next = HAS_PAR ? RX_PAR : RX_STOP;
         RX_PAR:   if (full_tick) rx_next = RX_STOP;
         RX_STOP:  if (full_tick) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1         <= 1'b1;
         rx_s          <= 1'b1;
         rx_prev       <= 1'b1;
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         rx_bit        <= '0;
         rx_shift      <= '0;
         par_bad       <= 1'b0;
         push_req      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         sync1    <= rx_in;
         rx_s     <= sync1;
         rx_prev  <= rx_s;
         rx_state <= rx_next;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt  <= '0;
               rx_bit  <= '0;
               par_bad <= 1'b0;
            end
            RX_START: rx_cnt <= half_tick ? '0 : rx_cnt + 1'b1;
            default:  rx_cnt <= full_tick ? '0 : rx_cnt + 1'b1;
         endcase
         if (rx_state == RX_DATA && full_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_bit   <= rx_bit + 1'b1;
         end
         if (rx_state == RX_PAR && full_tick)
            par_bad <= rx_s ^ (^rx_shift) ^ ODD_PAR;
         // Results register one cycle after the stop sample; rx_shift is
         // stable then because the FSM is back in IDLE.
         push_req      <= stop_sample && rx_s && !par_bad;
         rx_frame_err  <= stop_sample && !rx_s;
         rx_parity_err <= stop_sample && par_bad;
      end
   end

   // ------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic                 full, pop, push_ok;

   assign full     = (rx_count == (PW+1)'(FIFO_DEPTH));
   assign rx_valid = (rx_count != '0);
   assign pop      = rx_valid && rx_ready;
   assign push_ok  = push_req && (!full || pop);
   assign rx_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rx_count   <= '0;
         rx_overrun <= 1'b0;
      end else begin
         rx_overrun <= push_req && full && !pop;
         if (push_ok) begin
            mem[wr_ptr] <= rx_shift;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_trx_param.sv
// tb_uart_trx_param -- directed self-checking bench for uart_trx_param.
// dut0: CLK_DIV=16, 8 data bits, no parity, 4-entry FIFO.
// dut1: same but even parity; only its receiver is exercised.
// With UART_LOOPBACK_EN defined, dut0 also gets a loopback test.

module tb_uart_trx_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   // dut0 signals
   logic [7:0] tx_data0 = '0;
   logic       tx_valid0 = 1'b0;
   logic       tx_ready0, txd0;
   logic       rxd0 = 1'b1;
   logic [7:0] rx_data0;
   logic       rx_valid0;
   logic       rx_ready0 = 1'b0;
   logic [2:0] rx_count0;
   logic       rx_overrun0, rx_frame_err0, rx_parity_err0;
`ifdef UART_LOOPBACK_EN
   logic       loopback0 = 1'b0;
   logic       loopback1 = 1'b0;
`endif

   // dut1 signals
   logic       tx_ready1, txd1;
   logic       rxd1 = 1'b1;
   logic [7:0] rx_data1;
   logic       rx_valid1;
   logic       rx_ready1 = 1'b0;
   logic [2:0] rx_count1;
   logic       rx_overrun1, rx_frame_err1, rx_parity_err1;

   uart_trx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_LOOPBACK_EN
      .loopback(loopback0),
`endif
      .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .txd(txd0),
      .rxd(rxd0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
      .rx_count(rx_count0), .rx_overrun(rx_overrun0),
      .rx_frame_err(rx_frame_err0), .rx_parity_err(rx_parity_err0)
   );

   uart_trx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef UART_LOOPBACK_EN
      .loopback(loopback1),
`endif
      .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready1), .txd(txd1),
      .rxd(rxd1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
      .rx_count(rx_count1), .rx_overrun(rx_overrun1),
      .rx_frame_err(rx_frame_err1), .rx_parity_err(rx_parity_err1)
   );

   int total = 0;
   int bad   = 0;

   // pulse counters, sampled away from the active edge
   int ovr0 = 0, fe0 = 0, pe0 = 0, fe1 = 0, pe1 = 0;
   always @(negedge clk) begin
      if (rx_overrun0)    ovr0++;
      if (rx_frame_err0)  fe0++;
      if (rx_parity_err0) pe0++;
      if (rx_frame_err1)  fe1++;
      if (rx_parity_err1) pe1++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_line(input int line, input logic v);
      if (line == 0) rxd0 = v;
      else           rxd1 = v;
   endtask

   // Drive one serial frame, 16 cycles per bit, starting at a negedge.
   task automatic drive_frame(input int line, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stopb);
      set_line(line, 1'b0);
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_line(line, d[i]);
         repeat (16) @(negedge clk);
      end
      if (with_par) begin
         set_line(line, pbit);
         repeat (16) @(negedge clk);
      end
      set_line(line, stopb);
      repeat (16) @(negedge clk);
      set_line(line, 1'b1);
   endtask

   task automatic pop0();
      rx_ready0 = 1'b1;
      @(negedge clk);
      rx_ready0 = 1'b0;
   endtask

   // Send a byte on dut0 and check every bit at mid-bit plus tx_ready timing.
   task automatic tx_check(input logic [7:0] d);
      logic exp_bit;
      int   rdy_at;
      tx_data0  = d;
      tx_valid0 = 1'b1;
      @(negedge clk);
      tx_valid0 = 1'b0;
      tx_data0  = 8'($urandom);
      check($sformatf("tx_busy_%0h", d), tx_ready0, 1'b0);
      rdy_at = 0;
      for (int cyc = 1; cyc <= 170; cyc++) begin
         @(negedge clk);
         // a request while busy must be ignored
         if (cyc == 20) begin tx_valid0 = 1'b1; tx_data0 = ~d; end
         if (cyc == 21) tx_valid0 = 1'b0;
         if (cyc % 16 == 8 && cyc < 160) begin
            if (cyc / 16 == 0)      exp_bit = 1'b0;
            else if (cyc / 16 == 9) exp_bit = 1'b1;
            else                    exp_bit = d[cyc/16 - 1];
            check($sformatf("tx_%0h_bit%0d", d, cyc / 16), txd0, exp_bit);
         end
         if (tx_ready0 && rdy_at == 0) rdy_at = cyc;
      end
      check($sformatf("tx_%0h_ready_at", d), rdy_at, 160);
   endtask

   initial begin
      int lat;
      logic [7:0] bytes [5];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_txd", txd0, 1'b1);
      check("rst_tx_ready", tx_ready0, 1'b1);
      check("rst_rx_valid", rx_valid0, 1'b0);
      check("rst_rx_count", rx_count0, 0);
      check("rst_rx_data", rx_data0, 0);
      check("rst_errs", {rx_overrun0, rx_frame_err0, rx_parity_err0}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: transmit 0xA5
      tx_check(8'hA5);

      // 2: receive 0x3C, measure latency from start edge
      lat = 0;
      fork
         drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
         begin
            for (int c = 1; c <= 300; c++) begin
               @(negedge clk);
               if (rx_valid0) begin lat = c; break; end
            end
         end
      join
      check("rx_lat_window", (lat >= 148 && lat <= 160), 1'b1);
      check("rx_3c_data", rx_data0, 8'h3C);
      check("rx_3c_count", rx_count0, 1);
      pop0();
      check("rx_pop_valid", rx_valid0, 1'b0);
      check("rx_pop_count", rx_count0, 0);
      // pop on empty is ignored
      pop0();
      check("rx_empty_pop", rx_count0, 0);

      // 3: fill FIFO and overrun
      for (int i = 0; i < 4; i++) drive_frame(0, bytes[i], 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("fifo_count4", rx_count0, 4);
      check("fifo_no_ovr_yet", ovr0, 0);
      drive_frame(0, bytes[4], 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("fifo_still4", rx_count0, 4);
      check("fifo_ovr_once", ovr0, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fifo_pop%0d", i), rx_data0, bytes[i]);
         pop0();
      end
      check("fifo_drained", rx_valid0, 1'b0);

      // 4: even parity on dut1; 0x07 needs parity bit 1
      drive_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("par_err_pulse", pe1, 1);
      check("par_err_empty", rx_count1, 0);
      check("par_err_no_fe", fe1, 0);
      drive_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check("par_ok_valid", rx_valid1, 1'b1);
      check("par_ok_data", rx_data1, 8'h07);
      check("par_ok_no_pe", pe1, 1);

      // 5: glitch then framing error then recovery
      rxd0 = 1'b0;
      repeat (4) @(negedge clk);
      rxd0 = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_no_push", rx_count0, 0);
      check("glitch_no_flags", fe0 + pe0 + ovr0, 1);
      drive_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("frame_err_pulse", fe0, 1);
      check("frame_err_no_push", rx_count0, 0);
      repeat (16) @(negedge clk);
      drive_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check("recover_data", rx_data0, 8'h5A);
      check("recover_count", rx_count0, 1);
      pop0();

      // 6: reset mid data bit; dut1 still holds 0x07
      tx_data0  = 8'h00;
      tx_valid0 = 1'b1;
      @(negedge clk);
      tx_valid0 = 1'b0;
      repeat (35) @(negedge clk);
      check("pre_rst_txd_low", txd0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_txd", txd0, 1'b1);
      check("rst_mid_ready", tx_ready0, 1'b1);
      check("rst_fifo_lost", {rx_valid1, rx_count1}, 0);
      check("rst_rx_data1", rx_data1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      tx_check(8'h55);
      repeat (4) @(negedge clk);
      check("no_rx_without_loop", rx_count0, 0);

`ifdef UART_LOOPBACK_EN
      loopback0 = 1'b1;
      repeat (4) @(negedge clk);
      tx_check(8'h81);
      repeat (10) @(negedge clk);
      check("loop_valid", rx_valid0, 1'b1);
      check("loop_data", rx_data0, 8'h81);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog
   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog: got=timeout exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
